// File: rtl/elixirchip_es1_spu_op_popcnt_acc_if.sv
// elixirchip_es1_spu_op_popcnt_acc_if: term input and running-sum output bundle of the popcount accumulator
interface elixirchip_es1_spu_op_popcnt_acc_if #(
  parameter int DATA_BITS = 8,
  parameter int ACC_BITS  = 16
);
  logic [DATA_BITS-1:0] s_data;
  logic                 s_clear;
  logic                 s_valid;
  logic [ACC_BITS-1:0]  m_data;
  logic                 m_valid;
  logic                 m_last;
  logic                 m_overflow;
  modport master (output s_data, s_clear, s_valid, input m_data, m_valid, m_last, m_overflow);
  modport slave  (input s_data, s_clear, s_valid, output m_data, m_valid, m_last, m_overflow);
endinterface

// File: rtl/elixirchip_es1_spu_op_popcnt_acc.sv
// elixirchip_es1_spu_op_popcnt_acc: popcount each valid word and accumulate over windows of TERMS words.
// Define ELIXIRCHIP_ES1_SPU_OP_POPCNT_ACC_SAT_EN to saturate the sum and drive a sticky m_overflow.
module elixirchip_es1_spu_op_popcnt_acc #(
  parameter int    DATA_BITS  = 8,
  parameter int    ACC_BITS   = 16,
  parameter int    TERMS      = 4,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input logic reset_n,
  input logic clk,
  input logic cke,
  elixirchip_es1_spu_op_popcnt_acc_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int TC_W  = TERMS > 1 ? $clog2(TERMS) : 1;
  logic [CNT_W-1:0]    cnt, st1_cnt;
  logic                st1_valid, st1_clear;
  logic [TC_W-1:0]     tc, tc_base, tc_next;
  logic [ACC_BITS-1:0] acc, acc_next;
  logic                m_valid, m_last, ovf, ovf_next;
  logic                start, last;
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DATA_BITS; i++) cnt = cnt + CNT_W'(bus.s_data[i]);
  end
  // a clearing term is positioned as if the window had just begun
  assign tc_base = st1_clear ? '0 : tc;
  assign start   = tc_base == '0;
  assign last    = tc_base == TC_W'(TERMS - 1);
  assign tc_next = last ? '0 : tc_base + 1'b1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_POPCNT_ACC_SAT_EN
  logic [ACC_BITS:0] sum;
  assign sum      = {1'b0, acc} + (ACC_BITS + 1)'(st1_cnt);
  assign acc_next = start ? ACC_BITS'(st1_cnt) : sum[ACC_BITS] ? '1 : sum[ACC_BITS-1:0];
  assign ovf_next = ~start & (ovf | sum[ACC_BITS]);
`else
  assign acc_next = start ? ACC_BITS'(st1_cnt) : acc + ACC_BITS'(st1_cnt);
  assign ovf_next = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st1_cnt   <= '0;
      st1_valid <= 1'b0;
      st1_clear <= 1'b0;
      tc        <= '0;
      acc       <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      ovf       <= 1'b0;
    end else if (cke) begin
      st1_cnt   <= cnt;
      st1_valid <= bus.s_valid;
      st1_clear <= bus.s_clear;
      m_valid   <= st1_valid;
      m_last    <= st1_valid & last;
      if (st1_valid) begin
        acc <= acc_next;
        tc  <= tc_next;
        ovf <= ovf_next;
      end else if (st1_clear) begin
        acc <= '0;
        tc  <= '0;
        ovf <= 1'b0;
      end
    end
  end
  assign bus.m_data     = acc;
  assign bus.m_valid    = m_valid;
  assign bus.m_last     = m_last;
  assign bus.m_overflow = ovf;
endmodule

// File: tb/tb_elixirchip_es1_spu_op_popcnt_acc.sv
// tb_elixirchip_es1_spu_op_popcnt_acc: directed and random terms against a window-sum model, 16-bit and 4-bit accumulators
module tb_elixirchip_es1_spu_op_popcnt_acc;
  localparam int TERMS = 4;
  logic clk = 1'b0, run = 1'b0, reset_n = 1'b1, cke = 1'b0;
  elixirchip_es1_spu_op_popcnt_acc_if #(.DATA_BITS(8), .ACC_BITS(16)) bus_a ();
  elixirchip_es1_spu_op_popcnt_acc_if #(.DATA_BITS(8), .ACC_BITS(4))  bus_b ();
  elixirchip_es1_spu_op_popcnt_acc #(.DATA_BITS(8), .ACC_BITS(16), .TERMS(TERMS)) dut_a (
    .reset_n(reset_n), .clk(clk), .cke(cke), .bus(bus_a));
  elixirchip_es1_spu_op_popcnt_acc #(.DATA_BITS(8), .ACC_BITS(4), .TERMS(TERMS)) dut_b (
    .reset_n(reset_n), .clk(clk), .cke(cke), .bus(bus_b));
  always #5 clk = run ? ~clk : clk;
  int n_chk = 0, n_pass = 0;
  int sum = 0, n = 0;
  bit e_valid = 0, e_last = 0;
  bit p_v = 0, p_c = 0;
  logic [7:0] p_d = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic int exp_data(input int a);
    int mx = (1 << a) - 1;
`ifdef ELIXIRCHIP_ES1_SPU_OP_POPCNT_ACC_SAT_EN
    return sum > mx ? mx : sum;
`else
    return sum & mx;
`endif
  endfunction
  function automatic bit exp_ovf(input int a);
`ifdef ELIXIRCHIP_ES1_SPU_OP_POPCNT_ACC_SAT_EN
    return sum > (1 << a) - 1;
`else
    return a < 0;
`endif
  endfunction
  task automatic model_reset();
    sum = 0; n = 0; e_valid = 0; e_last = 0; p_v = 0; p_c = 0; p_d = '0;
  endtask
  task automatic model_apply(input bit v, input bit c, input logic [7:0] d);
    if (c) begin n = 0; sum = 0; end
    e_last = 0;
    if (v) begin
      if (n == 0) sum = 0;
      sum += $countones(d);
      n++;
      e_last = n == TERMS;
      if (e_last) n = 0;
    end
    e_valid = v;
  endtask
  task automatic compare_all(input string ph);
    check({ph, ".a_data"}, 32'(bus_a.m_data), exp_data(16));
    check({ph, ".a_valid"}, 32'(bus_a.m_valid), 32'(e_valid));
    check({ph, ".a_last"}, 32'(bus_a.m_last), 32'(e_last));
    check({ph, ".a_ovf"}, 32'(bus_a.m_overflow), 32'(exp_ovf(16)));
    check({ph, ".b_data"}, 32'(bus_b.m_data), exp_data(4));
    check({ph, ".b_valid"}, 32'(bus_b.m_valid), 32'(e_valid));
    check({ph, ".b_last"}, 32'(bus_b.m_last), 32'(e_last));
    check({ph, ".b_ovf"}, 32'(bus_b.m_overflow), 32'(exp_ovf(4)));
  endtask
  task automatic drive(input bit v, input bit c, input logic [7:0] d);
    bus_a.s_valid = v; bus_a.s_clear = c; bus_a.s_data = d;
    bus_b.s_valid = v; bus_b.s_clear = c; bus_b.s_data = d;
  endtask
  task automatic step(input string ph, input bit v, input bit c, input bit k, input logic [7:0] d);
    drive(v, c, d);
    cke = k;
    @(posedge clk);
    if (k) begin
      model_apply(p_v, p_c, p_d);
      p_v = v; p_c = c; p_d = d;
    end
    #1 compare_all(ph);
    @(negedge clk);
  endtask
  task automatic idle(input string ph, input int cyc);
    for (int i = 0; i < cyc; i++) step(ph, 0, 0, 1, 8'h00);
  endtask
  initial begin
    drive(0, 0, 8'h00);
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all("rst_async");
    run = 1'b1;
    repeat (3) @(negedge clk);
    compare_all("rst_hold");
    reset_n = 1'b1;
    idle("idle", 3);
    step("win", 1, 0, 1, 8'hFF);
    step("win", 1, 0, 1, 8'h0F);
    step("win", 1, 0, 1, 8'h01);
    step("win", 1, 0, 1, 8'h00);
    step("win", 1, 0, 1, 8'h03);
    idle("win", 3);
    step("clr", 1, 0, 1, 8'hFF);
    step("clr", 1, 0, 1, 8'hFF);
    step("clr", 1, 1, 1, 8'h07);
    for (int i = 0; i < 4; i++) step("clr", 1, 0, 1, 8'h01);
    step("clr", 0, 1, 1, 8'h00);
    idle("clr", 3);
    step("stall", 1, 0, 1, 8'hFF);
    step("stall", 1, 0, 0, 8'hFF);
    step("stall", 1, 0, 0, 8'h55);
    step("stall", 0, 1, 0, 8'h00);
    step("stall", 0, 0, 1, 8'h00);
    step("stall", 1, 0, 1, 8'hFF);
    step("stall", 0, 0, 1, 8'hAA);
    step("stall", 1, 0, 1, 8'hFF);
    step("stall", 1, 0, 0, 8'h0F);
    step("stall", 1, 0, 1, 8'hFF);
    idle("stall", 3);
    for (int i = 0; i < 8; i++) step("sat", 1, 0, 1, 8'hFF);
    idle("sat", 3);
    step("arst", 1, 0, 1, 8'hFF);
    step("arst", 1, 0, 1, 8'hFF);
    idle("arst", 2);
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all("arst_now");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step("arst", 1, 0, 1, 8'h0F);
    idle("arst", 3);
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 1) != 0 ? 8'hFF : 8'($urandom));
    idle("end", 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/elixirchip_es1_spu_op_popcnt_acc.md
Name: elixirchip_es1_spu_op_popcnt_acc

Overview:
- Consumer-side counterpart of the SPU bitwise ops (xnor/xor): takes the DATA_BITS-wide bitwise results, counts the ones in each word, and accumulates the counts over a window of TERMS valid words.
- Typical use: xnor-popcount dot products and Hamming-distance reduction.
- Sits directly downstream of a bitwise SPU op. Shares that op's cke/clear/valid convention.
- Emits a running sum each valid cycle and flags the last term of each window.

Parameters:
- DATA_BITS, 8: input word width.
- ACC_BITS, 16: accumulator/output width. Must be ≥ $clog2(DATA_BITS+1).
- TERMS, 4: valid words per accumulation window. Must be ≥1.
- DEVICE, "RTL": device name, passed through only.
- SIMULATION, "false": simulation flag.
- DEBUG, "false": debug flag.

Ports:
- reset_n  input  1  asynchronous reset, active-low.
- clk  input  1  clock.
- cke  input  1  clock enable. All state advances only when cke=1.
- s_data  input  DATA_BITS  input word, typically an xnor result.
- s_clear  input  1  abort the current window and restart it with this word.
- s_valid  input  1  s_data is a term.
- m_data  output  ACC_BITS  running accumulated popcount.
- m_valid  output  1  m_data was updated by a term this cycle.
- m_last  output  1  this m_data completes a window.
- m_overflow  output  1  sticky saturation flag. Tied 0 unless the optional feature is enabled.

Behaviour:
- Reset and clock:
  - One clock. Reset is asynchronous and active-low.
  - On reset_n=0, all registers clear immediately: m_data=0, m_valid=0, m_last=0, m_overflow=0, term counter=0, stage-1 registers=0.
  - Reset mid-window discards the partial sum.
- Stage 1 (when cke=1):
  - st1_cnt <= popcount(s_data), width $clog2(DATA_BITS+1).
  - st1_valid <= s_valid.
  - st1_clear <= s_clear.
- Stage 2 (when cke=1). State is the term counter tc, range 0..TERMS-1. tc=0 means window start (IDLE); otherwise ACCUM.
  - st1_clear=1, st1_valid=1: acc = zero-extended st1_cnt; tc = 1 (or 0 if TERMS=1).
  - st1_clear=1, st1_valid=0: acc = 0, tc = 0, m_valid=0.
  - st1_clear=0, st1_valid=1, tc=0: acc = st1_cnt. This is the window start.
  - st1_clear=0, st1_valid=1, tc>0: acc = m_data + st1_cnt.
  - In both valid cases: if tc = TERMS-1 then m_last=1 and tc returns to 0; else tc increments.
  - st1_valid=0 (no clear): m_data and tc hold; m_valid=0, m_last=0.
  - m_valid <= st1_valid.
- Latency: fixed 2 cycles of cke from s_valid to m_valid/m_data/m_last.
- cke=0: every register, including m_valid and m_last, holds its value (no bubble insertion).
- Clear priority: s_clear overrides window position. The clearing word, if valid, is term 1 of a new window.
- Arithmetic: unsigned. Without the optional feature, the accumulator wraps modulo 2^ACC_BITS.
- Back-to-back windows: the term following an m_last starts fresh from its own popcount, with no idle cycle.

Optional Feature:
- Macro: ELIXIRCHIP_ES1_SPU_OP_POPCNT_ACC_SAT_EN.
- Defined:
  - The sum saturates at 2^ACC_BITS-1 instead of wrapping.
  - m_overflow is set the cycle saturation first occurs.
  - m_overflow stays set until the next window start (tc=0 with valid), a clear, or reset.
  - m_last timing is unaffected.
- Undefined: the sum wraps; m_overflow is constant 0.

Test Plan:
1. Reset/idle: assert reset_n=0 with clk stopped, then release, hold s_valid=0 -> all outputs 0, asynchronously and on every cycle after release.
2. Window of 4 (DATA_BITS=8, TERMS=4, cke=1): s_data 0xFF, 0x0F, 0x01, 0x00 valid back-to-back -> 2 cycles later m_data 8, 12, 13, 13; m_last=1 only on the 4th; the next term 0x03 gives m_data 2, m_valid=1.
3. Clear mid-window: after 0xFF, 0xFF, send s_clear=1 with s_data=0x07 valid -> m_data 8, 16, then 3. m_last fires 3 terms after the clear, not 4 from the window start.
4. cke stall and valid gaps: drop cke for 3 cycles and insert s_valid=0 gaps -> outputs frozen while cke=0; no term lost or duplicated; m_data 8, 16, 24, 32 for all-0xFF input.
5. Wrap vs saturate (ACC_BITS=4, TERMS=4, all-0xFF input): macro undefined -> m_data 8, 0, 8, 0. Macro defined -> 8, 15, 15, 15 with m_overflow rising on the 2nd term; m_overflow clears on the first term of the next window.
6. Async reset mid-window: pull reset_n low between clock edges after 2 terms -> m_data=0 immediately; the first term after release starts a new window (tc=1).
